// File: rtl/right_shift_seq.sv
// Multi-cycle right shifter (SRL/SRA): one power-of-two stage per clock,
// largest stage first, under a start/busy/done handshake.
module right_shift_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHAMT_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  localparam int unsigned STAGE_W = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;
  localparam int unsigned POW_W   = SHAMT_BITS + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       work_q, work_d;
  logic [SHAMT_BITS-1:0]  amt_q, amt_d;
  logic                   fill_q, fill_d;
  logic [STAGE_W-1:0]     stage_q, stage_d;
  logic [WIDTH-1:0]       r_d;
  logic                   busy_d, done_d;

  logic [POW_W-1:0]       step;
  logic [WIDTH-1:0]       fill_mask;
  logic [WIDTH-1:0]       stepped;

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      stage_q <= '0;
      R       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
      R       <= r_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, single shift stage and handshake outputs.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    stage_d = stage_q;
    r_d     = R;
    busy_d  = busy;
    done_d  = 1'b0;

    // Shift work right by 2^stage, filling vacated high bits with fill.
    step      = POW_W'(1) << stage_q;
    fill_mask = ~({WIDTH{1'b1}} >> step);
    stepped   = (work_q >> step) | (fill_q ? fill_mask : '0);

    case (state_q)
      IDLE: begin
        if (busy) begin
          // Busy while idle means an overflowing shift was accepted last edge.
          r_d    = {WIDTH{fill_q}};
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (start) begin
          work_d = A;
          amt_d  = B[SHAMT_BITS-1:0];
          fill_d = arith & A[WIDTH-1];
          busy_d = 1'b1;
          if (B[WIDTH-1:SHAMT_BITS] == '0) begin
            state_d = SHIFT;
            stage_d = STAGE_W'(SHAMT_BITS - 1);
          end
        end
      end
      SHIFT: begin
        if (amt_q[stage_q]) begin
          work_d = stepped;
        end
        if (stage_q == '0) begin
          r_d     = work_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          stage_d = stage_q - STAGE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_right_shift_seq.sv
// Scoreboard bench for right_shift_seq: expected results and latencies are
// queued when a request is accepted and compared when done pulses.
module tb_right_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        arith;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] R;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int e0       = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  right_shift_seq #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .arith (arith),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference shifter written directly from the instruction semantics.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ar);
    logic [31:0] sign_fill;
    sign_fill = {32{a[31]}};
    if (b >= 32) return ar ? sign_fill : 32'h0;
    if (ar) return 32'($signed(a) >>> b[4:0]);
    return a >> b[4:0];
  endfunction

  // Drive one request while idle and queue its expected result and latency.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ar);
    @(negedge clk);
    A = a; B = b; arith = ar; start = 1'b1;
    exp_q.push_back(model(a, b, ar));
    lat_q.push_back((b >= 32) ? 1 : 5);
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; counts cycles where busy was wrong on the way.
  task automatic wait_done(output logic got, output logic [31:0] r, output int lat,
                           output int busy_bad);
    got = 1'b0; r = '0; lat = -1; busy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; r = R; lat = cyc - e0;
        if (busy) busy_bad++;
        break;
      end else if (!busy) begin
        busy_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; arith = 1'b0; A = '0; B = '0;
    #12;
    checks++; if (R !== 32'h0) begin failures++; $display("FAIL reset_R got=%h want=00000000", R); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_shift();
    logic [31:0] ta[6] = '{32'h80000000, 32'h80000000, 32'h12345678, 32'h87654321, 32'h7FFFFFFF, 32'hDEADBEEF};
    logic [31:0] tb[6] = '{32'd4, 32'd4, 32'd0, 32'd31, 32'd31, 32'd13};
    logic        tr[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic got; logic [31:0] r, ex; int lat, el, bb;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i], tr[i]);
      wait_done(got, r, lat, bb);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL shift[%0d] no done within bound", i); end
      else begin
        checks++; if (r !== ex) begin failures++; $display("FAIL shift[%0d]_R got=%h want=%h", i, r, ex); end
        checks++; if (lat != el) begin failures++; $display("FAIL shift[%0d]_latency got=%0d want=%0d", i, lat, el); end
        checks++; if (bb != 0) begin failures++; $display("FAIL shift[%0d]_busy bad_cycles=%0d want=0", i, bb); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] tb[4] = '{32'd32, 32'd32, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        tr[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic got; logic [31:0] r, ex; int lat, el, bb;
    for (int i = 0; i < 4; i++) begin
      start_op(32'h80000001, tb[i], tr[i]);
      wait_done(got, r, lat, bb);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL ovf[%0d] no done within bound", i); end
      else begin
        checks++; if (r !== ex) begin failures++; $display("FAIL ovf[%0d]_R got=%h want=%h", i, r, ex); end
        checks++; if (lat != el) begin failures++; $display("FAIL ovf[%0d]_latency got=%0d want=%0d", i, lat, el); end
        checks++; if (bb != 0) begin failures++; $display("FAIL ovf[%0d]_busy bad_cycles=%0d want=0", i, bb); end
      end
    end
  endtask

  task automatic test_ignore_start();
    logic got; logic [31:0] r, ex; int lat, el, bb;
    start_op(32'hF0F0F0F0, 32'd8, 1'b0);
    repeat (2) @(negedge clk);
    A = 32'hFFFFFFFF; B = 32'd1; arith = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(got, r, lat, bb);
    ex = exp_q.pop_front(); el = lat_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL ignore no done within bound"); end
    else begin
      checks++; if (r !== ex) begin failures++; $display("FAIL ignore_R got=%h want=%h", r, ex); end
      checks++; if (lat != el) begin failures++; $display("FAIL ignore_latency got=%0d want=%0d", lat, el); end
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL ignore_done_pulse got=%b want=0", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%b want=0", busy); end
      checks++; if (R !== ex) begin failures++; $display("FAIL ignore_R_hold got=%h want=%h", R, ex); end
    end
  endtask

  task automatic test_reset_mid();
    logic got; logic [31:0] r, ex; int lat, el, bb;
    start_op(32'h80000000, 32'd4, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete(); lat_q.delete();
    checks++; if (R !== 32'h0) begin failures++; $display("FAIL midrst_R got=%h want=00000000", R); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b want=0", done); end
    @(negedge clk);
    rst = 1'b0;
    start_op(32'h40000000, 32'd2, 1'b1);
    wait_done(got, r, lat, bb);
    ex = exp_q.pop_front(); el = lat_q.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL midrst_after no done within bound"); end
    else begin
      checks++; if (r !== ex) begin failures++; $display("FAIL midrst_after_R got=%h want=%h", r, ex); end
      checks++; if (lat != el) begin failures++; $display("FAIL midrst_after_latency got=%0d want=%0d", lat, el); end
    end
  endtask

  task automatic test_back_to_back();
    logic got; logic [31:0] r, ex; int lat, el, bb;
    @(negedge clk);
    A = 32'hF0000000; B = 32'd1; arith = 1'b0; start = 1'b1;
    exp_q.push_back(model(32'hF0000000, 32'd1, 1'b0));  lat_q.push_back(5);
    exp_q.push_back(model(32'hF0000000, 32'd31, 1'b0)); lat_q.push_back(5);
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    B = 32'd31;
    for (int k = 0; k < 2; k++) begin
      wait_done(got, r, lat, bb);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL b2b[%0d] no done within bound", k); end
      else begin
        checks++; if (r !== ex) begin failures++; $display("FAIL b2b[%0d]_R got=%h want=%h", k, r, ex); end
        checks++; if (lat != el) begin failures++; $display("FAIL b2b[%0d]_latency got=%0d want=%0d", k, lat, el); end
        checks++; if (bb != 0) begin failures++; $display("FAIL b2b[%0d]_busy bad_cycles=%0d want=0", k, bb); end
      end
      if (k == 0) begin
        // start is still high while done=1, so the next edge accepts the second request.
        e0 = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b want=0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_busy got=%b want=1", busy); end
      end
    end
  endtask

  task automatic test_random();
    logic got; logic [31:0] r, ex, a, b; logic ar; int lat, el, bb;
    for (int i = 0; i < 10; i++) begin
      a  = $urandom;
      b  = (i == 9) ? $urandom : 32'($urandom_range(0, 40));
      ar = 1'($urandom_range(0, 1));
      start_op(a, b, ar);
      wait_done(got, r, lat, bb);
      ex = exp_q.pop_front(); el = lat_q.pop_front();
      checks++;
      if (!got) begin failures++; $display("FAIL rand[%0d] no done within bound", i); end
      else begin
        checks++; if (r !== ex) begin failures++; $display("FAIL rand[%0d]_R a=%h b=%h arith=%b got=%h want=%h", i, a, b, ar, r, ex); end
        checks++; if (lat != el) begin failures++; $display("FAIL rand[%0d]_latency got=%0d want=%0d", i, lat, el); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
